// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, mid-bit sampling.
// Good frames strobe o_RX_DV with the byte; a low stop bit strobes o_RX_Frame_Err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP,
    RECOVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic             rx_m;
  logic             rx_s;
  logic [7:0]       shift;
  logic             data_sample;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_RX_Serial;
      rx_s <= rx_m;
    end
  end

  assign data_sample = (state == DATA) && (clk_cnt == LAST);

  // Assembly register is never delivered until all eight bits are rewritten,
  // so it needs no reset.
  always_ff @(posedge i_Clock) begin
    if (data_sample) begin
      shift[bit_idx] <= rx_s;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      o_RX_Active    <= 1'b0;
      o_RX_Byte      <= 8'h00;
    end else begin
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state       <= START;
            o_RX_Active <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state       <= IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == LAST) begin
            clk_cnt     <= '0;
            o_RX_Active <= 1'b0;
            if (rx_s) begin
              o_RX_Byte <= shift;
              o_RX_DV   <= 1'b1;
              state     <= CLEANUP;
            end else begin
              o_RX_Frame_Err <= 1'b1;
              state          <= RECOVER;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        CLEANUP: begin
          clk_cnt <= '0;
          state   <= IDLE;
        end
        RECOVER: begin
          // Hold off until the line returns high so a break is not read as 0x00 frames.
          clk_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          clk_cnt     <= '0;
          o_RX_Active <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for timing, back-to-back, glitch, break and mid-frame reset.
module tb_uart_rx;
  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_RX_Serial   (rx),
    .o_RX_DV       (dv),
    .o_RX_Byte     (rx_byte),
    .o_RX_Active   (active),
    .o_RX_Frame_Err(ferr)
  );

  always #5 clk = ~clk;

  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  int         dv_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         rise_cnt = 0;
  int         last_dv_pc = 0;
  int         last_rise_pc = 0;
  int         last_fall_pc = 0;
  logic       act_prev = 1'b0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    act_prev <= active;
    if (dv) begin
      dv_cnt     <= dv_cnt + 1;
      last_dv_pc <= pc;
      rx_q.push_back(rx_byte);
    end
    if (ferr) err_cnt <= err_cnt + 1;
    if (dv && ferr) both_cnt <= both_cnt + 1;
    if (active && !act_prev) begin
      rise_cnt     <= rise_cnt + 1;
      last_rise_pc <= pc;
    end
    if (!active && act_prev) last_fall_pc <= pc;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int per);
    rx = v;
    repeat (per) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int per, input logic stop);
    send_bit(1'b0, per);
    for (int i = 0; i < 8; i++) send_bit(d[i], per);
    send_bit(stop, per);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         per;
    logic       stop;
    int         exp_dv;
    logic [7:0] exp_byte;
    int         exp_err;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] b2b[6];
  int         n0, d0, e0, r0, q0;

  initial begin
    vecs[0] = '{data: 8'hB4, per: 84, stop: 1'b1, exp_dv: 1, exp_byte: 8'hB4, exp_err: 0};
    vecs[1] = '{data: 8'hB4, per: 90, stop: 1'b1, exp_dv: 1, exp_byte: 8'hB4, exp_err: 0};
    vecs[2] = '{data: 8'h00, per: 87, stop: 1'b1, exp_dv: 1, exp_byte: 8'h00, exp_err: 0};
    vecs[3] = '{data: 8'hFF, per: 87, stop: 1'b1, exp_dv: 1, exp_byte: 8'hFF, exp_err: 0};
    vecs[4] = '{data: 8'h55, per: 87, stop: 1'b0, exp_dv: 0, exp_byte: 8'hFF, exp_err: 1};
    vecs[5] = '{data: 8'hA5, per: 87, stop: 1'b1, exp_dv: 1, exp_byte: 8'hA5, exp_err: 0};
    vecs[6] = '{data: 8'h5A, per: 84, stop: 1'b1, exp_dv: 1, exp_byte: 8'h5A, exp_err: 0};
    b2b = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80};

    // Reset state
    settle(3);
    chk("reset_dv", int'(dv), 0);
    chk("reset_err", int'(ferr), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_byte", int'(rx_byte), 8'h00);
    rst_n = 1'b1;
    settle(10);

    // Single byte with exact strobe timing
    n0 = pc; d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h37, CPB, 1'b1);
    settle(2 * CPB);
    chk("single_dv_count", dv_cnt - d0, 1);
    chk("single_byte", int'(rx_byte), 8'h37);
    chk("single_err_count", err_cnt - e0, 0);
    chk("single_dv_cycle", last_dv_pc - n0, 830);
    chk("single_active_rise", last_rise_pc - n0, 3);
    chk("single_active_fall", last_fall_pc - n0, 830);

    // Table of isolated frames
    for (int i = 0; i < 7; i++) begin
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].per, vecs[i].stop);
      rx = 1'b1;
      settle(2 * CPB);
      chk($sformatf("vec%0d_dv", i), dv_cnt - d0, vecs[i].exp_dv);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_byte", i), int'(rx_byte), int'(vecs[i].exp_byte));
    end

    // Back-to-back frames with no idle gap
    q0 = rx_q.size(); r0 = rise_cnt; e0 = err_cnt;
    for (int i = 0; i < 6; i++) send_frame(b2b[i], CPB, 1'b1);
    settle(2 * CPB);
    chk("b2b_count", rx_q.size() - q0, 6);
    for (int i = 0; i < 6; i++)
      if (q0 + i < rx_q.size()) chk($sformatf("b2b_byte%0d", i), int'(rx_q[q0 + i]), int'(b2b[i]));
    chk("b2b_active_rises", rise_cnt - r0, 6);
    chk("b2b_err", err_cnt - e0, 0);

    // Start glitch shorter than half a bit
    d0 = dv_cnt; e0 = err_cnt;
    send_bit(1'b0, 20);
    rx = 1'b1;
    settle(3 * CPB);
    chk("glitch_dv", dv_cnt - d0, 0);
    chk("glitch_err", err_cnt - e0, 0);
    send_frame(8'hC3, CPB, 1'b1);
    settle(2 * CPB);
    chk("after_glitch_dv", dv_cnt - d0, 1);
    chk("after_glitch_byte", int'(rx_byte), 8'hC3);

    // Framing error followed by a long break
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h55, CPB, 1'b0);
    send_bit(1'b0, 30 * CPB);
    rx = 1'b1;
    settle(2 * CPB);
    chk("break_err", err_cnt - e0, 1);
    chk("break_dv", dv_cnt - d0, 0);
    chk("break_byte_held", int'(rx_byte), 8'hC3);
    send_frame(8'h12, CPB, 1'b1);
    settle(2 * CPB);
    chk("after_break_dv", dv_cnt - d0, 1);
    chk("after_break_byte", int'(rx_byte), 8'h12);

    // Reset asserted during data bit 4 of 0x9E
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(((8'h9E >> i) & 8'h01) != 0, CPB);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", int'(dv), 0);
    chk("midrst_err", int'(ferr), 0);
    chk("midrst_active", int'(active), 0);
    chk("midrst_byte", int'(rx_byte), 8'h00);
    repeat (47) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(((8'h9E >> i) & 8'h01) != 0, CPB);
    send_bit(1'b1, CPB);
    repeat (20) @(negedge clk);
    d0 = dv_cnt; e0 = err_cnt;
    rst_n = 1'b1;
    settle(3 * CPB);
    chk("postrst_dv", dv_cnt - d0, 0);
    chk("postrst_err", err_cnt - e0, 0);
    chk("postrst_byte", int'(rx_byte), 8'h00);
    send_frame(8'h6B, CPB, 1'b1);
    settle(2 * CPB);
    chk("postrst_frame_dv", dv_cnt - d0, 1);
    chk("postrst_frame_byte", int'(rx_byte), 8'h6B);

    chk("strobe_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of `uart_tx`: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It synchronises the asynchronous `i_RX_Serial` pin and samples each bit at its midpoint. It presents each received byte with a one-cycle valid strobe and flags framing errors. It sits between the board RX pin and the byte-level consumer (FIFO or command parser), and must interoperate directly with `uart_tx` when both use the same `CLKS_PER_BIT`.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit (clock frequency / baud). Legal range 4..65535.
- `i_Clock`  in  1: system clock; all logic is on the rising edge.
- `i_Rst_L`  in  1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `i_Clock` and is guaranteed by the system.
- `i_RX_Serial`  in  1: serial line, asynchronous to `i_Clock`, idles high.
- `o_RX_DV`  out  1: one-cycle strobe; `o_RX_Byte` is valid on this cycle.
- `o_RX_Byte`  out  8: last correctly received byte; holds its value until the next good byte.
- `o_RX_Active`  out  1: high while a frame is being received.
- `o_RX_Frame_Err`  out  1: one-cycle strobe when the stop bit is sampled low.

## Operation
- **Input synchroniser:** two-flop synchroniser on `i_RX_Serial`. Both flops reset to 1. Only the second-stage output (`rx_s`) is used downstream.
- **Bit counter:** `clk_cnt` has width `$clog2(CLKS_PER_BIT)` and is cleared on every state transition. `bit_idx` is 3 bits.
- **Half-bit value:** `H = (CLKS_PER_BIT-1)/2` (integer division).
- **States:** IDLE, START, DATA, STOP, CLEANUP, RECOVER.
  - IDLE: when `rx_s == 0`, go to START with `clk_cnt = 0`.
  - START: count until `clk_cnt == H`, then sample.
    - `rx_s == 0`: go to DATA with `bit_idx = 0`.
    - `rx_s == 1`: glitch; return to IDLE with no output activity.
  - DATA: count until `clk_cnt == CLKS_PER_BIT-1`, then sample `rx_s` into shift bit `bit_idx`.
    - If `bit_idx == 7`, go to STOP; otherwise increment `bit_idx`.
  - STOP: count until `clk_cnt == CLKS_PER_BIT-1`, then sample.
    - High: load `o_RX_Byte` from the shift register, pulse `o_RX_DV`, go to CLEANUP.
    - Low: pulse `o_RX_Frame_Err`, leave `o_RX_Byte` unchanged, go to RECOVER.
  - CLEANUP: one cycle, then IDLE.
  - RECOVER: wait until `rx_s == 1`, then IDLE. This prevents a break condition (line held low) from being decoded as repeated 0x00 frames.
- **`o_RX_Active`:** high in START, DATA and STOP; low in all other states.
- **Data path:** the shift register and `o_RX_Byte` are separate registers. A frame in progress never disturbs the previously delivered byte.

## Timing
- **Reset values:** `o_RX_DV = 0`, `o_RX_Frame_Err = 0`, `o_RX_Active = 0`, `o_RX_Byte = 8'h00`, state IDLE, counters 0, synchroniser flops 1.
- **Reference point:** let T0 be the first cycle `rx_s` is low in IDLE. T0 is 2 cycles after the raw falling edge is captured.
- **Start check:** the start-bit midpoint is checked at T0+1+H.
- **Data samples:** bit k (k = 0..7) is sampled at T0+1+H+(k+1)·CLKS_PER_BIT.
- **Stop sample:** the stop bit is sampled at T0+1+H+9·CLKS_PER_BIT.
- **Result strobes:** `o_RX_DV` or `o_RX_Frame_Err` is high for exactly one cycle, the cycle after the stop sample. `o_RX_Byte` updates on that same edge.
- **`o_RX_Active`:** rises at T0+1 and falls on the same edge that raises `o_RX_DV` or `o_RX_Frame_Err`.
- **Back-to-back frames:** after a good stop bit, the earliest next start detection is 2 cycles after the strobe (CLEANUP, then IDLE). This is inside the remaining half stop bit, so zero-gap frames from `uart_tx` are received without loss.
- **Strobe exclusivity:** `o_RX_DV` and `o_RX_Frame_Err` are never high together.
- **Reset mid-frame:** reset asserted in any state returns all outputs to their reset values immediately. The partial frame is discarded and no strobe is issued. After release, reception begins only on a fresh falling edge seen in IDLE.
- **No flow control:** the consumer must accept the strobe cycle. There is no backpressure.

## Test plan
- **Single byte:** CLKS_PER_BIT=87, drive frame 0x37 with ideal timing → exactly one `o_RX_DV` pulse at T0+1+43+783+1; `o_RX_Byte = 8'h37`; `o_RX_Frame_Err` never asserted.
- **Loopback:** `uart_tx` → `uart_rx`, bytes 0x00, 0xFF, 0xA5, 0x5A, 0x01, 0x80 sent back-to-back with `i_TX_DV` re-asserted on each `o_TX_Done` → six DV pulses, bytes match in order, `o_RX_Active` low only between frames.
- **Start glitch:** low pulse of 20 cycles (< H) on an idle line → no DV and no error; state back in IDLE; a following frame 0xC3 is received correctly.
- **Framing error:** frame 0x55 with stop bit low, then line held low for 30 bit times, then released → one `o_RX_Frame_Err` pulse; `o_RX_Byte` keeps its previous value (0xC3); no DV pulses during the break; the next frame 0x12 is received.
- **Reset mid-frame:** assert `i_Rst_L` low during data bit 4 of 0x9E → all outputs 0 immediately; after release, no strobe from the truncated frame; the next full frame 0x6B yields DV with 0x6B.
- **Baud tolerance:** transmit 0xB4 at ±3% bit period (84 and 90 cycles per bit) → byte received correctly in both cases.
